fft_pingpong_buf: RTL and testbench

FFT_PINGPONG_BUF -- requirements
Module: fft_pingpong_buf

---
 rtl/fft_buf_pkg.sv | 24 ++
 rtl/sp_ram_cplx.sv | 55 +++++
 rtl/fft_pingpong_buf.sv | 182 ++++++++++++++++++
 tb/tb_fft_pingpong_buf.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT ping-pong buffer: bank ownership states and
// the address bit-reversal used when loading frames in bit-reversed order.
package fft_buf_pkg;

  typedef enum logic [1:0] {
    BANK_FREE = 2'd0,
    BANK_FILL = 2'd1,
    BANK_FULL = 2'd2,
    BANK_CORE = 2'd3
  } bank_state_e;

  localparam int MAX_LOG2N = 16;

  // Reverses the low nbits of v; bits above nbits come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bit_reverse(input logic [MAX_LOG2N-1:0] v,
                                                       input int unsigned nbits);
    logic [MAX_LOG2N-1:0] full;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      full[i] = v[MAX_LOG2N-1-i];
    end
    return full >> (MAX_LOG2N - nbits);
  endfunction

endpackage

// File: rtl/sp_ram_cplx.sv
// Single-port complex-sample RAM with a registered read port and an optional
// second output register; read data holds whenever no read is issued.
module sp_ram_cplx #(
  parameter int LOG2N    = 11,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [LOG2N-1:0] addr_i,
  input  logic [DW-1:0]    din_i,
  output logic [DW-1:0]    dout_o
);

  logic [DW-1:0] mem_q [0:(1<<LOG2N)-1];
  logic [DW-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (en_i && !we_i) begin
      rd_q <= mem_q[addr_i];
    end
  end

  generate
    if (READ_LAT == 2) begin : g_oreg
      logic          rd_vld_q;
      logic [DW-1:0] out_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_vld_q <= 1'b0;
          out_q    <= '0;
        end else begin
          rd_vld_q <= en_i && !we_i;
          if (rd_vld_q) begin
            out_q <= rd_q;
          end
        end
      end
      assign dout_o = out_q;
    end else begin : g_bypass
      assign dout_o = rd_q;
    end
  endgenerate

endmodule

// File: rtl/fft_pingpong_buf.sv
// Two-bank ping-pong frame buffer between a sample stream and an in-place FFT
// core; the input fills one bank while the core owns the other.
//
//   state | meaning
//   FREE  | idle, waiting to become the fill bank
//   FILL  | receiving input samples at cnt (natural or bit-reversed)
//   FULL  | complete frame waiting for the core
//   CORE  | owned by the core for read/in-place write-back
module fft_pingpong_buf
  import fft_buf_pkg::*;
#(
  parameter int LOG2N    = 11,
  parameter int W        = 16,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bitrev_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_re,
  input  logic [W-1:0]     in_im,
  output logic             frame_rdy,
  output logic             frame_start,
  input  logic [LOG2N-1:0] core_ad,
  input  logic             core_wre,
  input  logic [W-1:0]     core_din_re,
  input  logic [W-1:0]     core_din_im,
  output logic [W-1:0]     core_dout_re,
  output logic [W-1:0]     core_dout_im,
  input  logic             core_done,
  output logic             overrun
);

  bank_state_e st_q [2];
  bank_state_e st_d [2];

  logic [LOG2N-1:0]     cnt_q, cnt_d;
  logic                 bitrev_q, bitrev_d;
  logic                 in_ready_q, frame_start_q, overrun_q;
  logic                 any_fill, any_core, next_fill, enter_core;
  logic                 fill_we, fill_done, core_bank, core_rd;
  logic [MAX_LOG2N-1:0] rev_full;
  logic [LOG2N-1:0]     fill_addr;
  logic [2*W-1:0]       bank_dout [2];
  logic                 out_sel_q;

  assign any_fill  = (st_q[0] == BANK_FILL) || (st_q[1] == BANK_FILL);
  assign any_core  = (st_q[0] == BANK_CORE) || (st_q[1] == BANK_CORE);
  assign core_bank = (st_q[1] == BANK_CORE);
  assign core_rd   = any_core && !core_wre;
  assign fill_we   = in_valid && in_ready_q;
  assign fill_done = fill_we && (cnt_q == '1);

  assign rev_full  = bit_reverse(MAX_LOG2N'(cnt_q), LOG2N);
  assign fill_addr = bitrev_q ? rev_full[LOG2N-1:0] : cnt_q;

  // Bank transitions look only at current states, so a bank finishing its fill
  // and a bank being released never hand over within the same cycle.
  always_comb begin
    st_d     = st_q;
    bitrev_d = bitrev_q;
    cnt_d    = cnt_q;
    if (fill_we) begin
      cnt_d = fill_done ? '0 : cnt_q + 1'b1;
    end
    for (int b = 0; b < 2; b++) begin
      case (st_q[b])
        BANK_FILL: if (fill_done) st_d[b] = BANK_FULL;
        BANK_FREE: begin
          if (!any_fill && !(b == 1 && st_q[0] == BANK_FREE)) begin
            st_d[b]  = BANK_FILL;
            bitrev_d = bitrev_en;
          end
        end
        BANK_FULL: begin
          if (!any_core && !(b == 1 && st_q[0] == BANK_FULL)) begin
            st_d[b] = BANK_CORE;
          end
        end
        BANK_CORE: if (core_done) st_d[b] = BANK_FREE;
        default: ;
      endcase
    end
  end

  assign next_fill  = (st_d[0] == BANK_FILL) || (st_d[1] == BANK_FILL);
  assign enter_core = ((st_q[0] == BANK_FULL) && (st_d[0] == BANK_CORE)) ||
                      ((st_q[1] == BANK_FULL) && (st_d[1] == BANK_CORE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q[0]       <= BANK_FILL;
      st_q[1]       <= BANK_FREE;
      cnt_q         <= '0;
      bitrev_q      <= bitrev_en;
      in_ready_q    <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      bitrev_q      <= bitrev_d;
      in_ready_q    <= next_fill;
      frame_start_q <= enter_core;
      if (in_valid && !in_ready_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic             en, we;
    logic [LOG2N-1:0] addr;
    logic [2*W-1:0]   din;

    always_comb begin
      en   = 1'b0;
      we   = 1'b0;
      addr = fill_addr;
      din  = {in_re, in_im};
      if (st_q[b] == BANK_FILL) begin
        en = fill_we;
        we = 1'b1;
      end else if (st_q[b] == BANK_CORE) begin
        en   = 1'b1;
        we   = core_wre;
        addr = core_ad;
        din  = {core_din_re, core_din_im};
      end
    end

    sp_ram_cplx #(
      .LOG2N   (LOG2N),
      .DW      (2*W),
      .READ_LAT(READ_LAT)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .we_i  (we),
      .addr_i(addr),
      .din_i (din),
      .dout_o(bank_dout[b])
    );
  end

  // The output mux follows the bank whose read data is landing, so it moves
  // with the same latency as the RAM output and otherwise holds.
  generate
    if (READ_LAT == 2) begin : g_sel2
      logic sel1_q, rd1_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sel1_q    <= 1'b0;
          rd1_q     <= 1'b0;
          out_sel_q <= 1'b0;
        end else begin
          rd1_q <= core_rd;
          if (core_rd) sel1_q <= core_bank;
          if (rd1_q) out_sel_q <= sel1_q;
        end
      end
    end else begin : g_sel1
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_sel_q <= 1'b0;
        end else if (core_rd) begin
          out_sel_q <= core_bank;
        end
      end
    end
  endgenerate

  assign {core_dout_re, core_dout_im} = bank_dout[out_sel_q];

  assign in_ready    = in_ready_q;
  assign frame_rdy   = any_core;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// Self-checking bench: random frames streamed through the buffer and compared
// against an address-level model of what the core should see.
module tb_fft_pingpong_buf;
  localparam int LOG2N = 3;
  localparam int W     = 16;
  localparam int N     = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, bitrev_en, in_valid, core_wre, core_done;
  logic [W-1:0]     in_re, in_im, core_din_re, core_din_im;
  logic [LOG2N-1:0] core_ad;
  logic             in_ready, frame_rdy, frame_start, overrun;
  logic [W-1:0]     core_dout_re, core_dout_im;
  logic             in_ready2, frame_rdy2, frame_start2, overrun2;
  logic [W-1:0]     core_dout_re2, core_dout_im2;

  fft_pingpong_buf #(.LOG2N(LOG2N), .W(W), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bitrev_en(bitrev_en), .in_valid(in_valid),
    .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .frame_rdy(frame_rdy),
    .frame_start(frame_start), .core_ad(core_ad), .core_wre(core_wre),
    .core_din_re(core_din_re), .core_din_im(core_din_im),
    .core_dout_re(core_dout_re), .core_dout_im(core_dout_im),
    .core_done(core_done), .overrun(overrun));

  fft_pingpong_buf #(.LOG2N(LOG2N), .W(W), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bitrev_en(bitrev_en), .in_valid(in_valid),
    .in_ready(in_ready2), .in_re(in_re), .in_im(in_im), .frame_rdy(frame_rdy2),
    .frame_start(frame_start2), .core_ad(core_ad), .core_wre(core_wre),
    .core_din_re(core_din_re), .core_din_im(core_din_im),
    .core_dout_re(core_dout_re2), .core_dout_im(core_dout_im2),
    .core_done(core_done), .overrun(overrun2));

  int errors = 0;
  int checks = 0;

  logic [15:0] fre [4][N];
  logic [15:0] fim [4][N];
  logic [31:0] exp_mem [N];

  function automatic int rev3(input int k);
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + ((k / 4) % 2);
  endfunction

  task automatic gen_random(input int f);
    for (int k = 0; k < N; k++) begin
      fre[f][k] = 16'($urandom);
      fim[f][k] = 16'($urandom);
    end
  endtask

  task automatic build_expected(input int f, input bit br);
    for (int k = 0; k < N; k++) exp_mem[br ? rev3(k) : k] = {fre[f][k], fim[f][k]};
  endtask

  task automatic do_reset(input bit br);
    rst_n = 1'b0; bitrev_en = br; in_valid = 1'b0; core_wre = 1'b0; core_done = 1'b0;
    in_re = '0; in_im = '0; core_din_re = '0; core_din_im = '0; core_ad = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_sample(input logic [15:0] re, input logic [15:0] im, output bit ok);
    int t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    ok = (in_ready === 1'b1);
    if (ok) begin
      in_valid = 1'b1; in_re = re; in_im = im;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int f, input int from, input int upto, output bit ok);
    bit one;
    ok = 1'b1;
    for (int k = from; k < upto; k++) begin
      send_sample(fre[f][k], fim[f][k], one);
      ok &= one;
    end
  endtask

  task automatic wait_start(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (frame_start === 1'b1) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic core_read(input int ad, output logic [31:0] d);
    core_ad = LOG2N'(ad); core_wre = 1'b0;
    @(negedge clk);
    d = {core_dout_re, core_dout_im};
  endtask

  task automatic core_release();
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (frame_rdy !== 1'b0) begin errors++; $display("FAIL reset_frame_rdy: got %b expected 0", frame_rdy); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if ({core_dout_re, core_dout_im} !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", {core_dout_re, core_dout_im}); end
    checks++; if ({core_dout_re2, core_dout_im2} !== 32'h0) begin errors++; $display("FAIL reset_dout_lat2: got %h expected 0", {core_dout_re2, core_dout_im2}); end
  endtask

  task automatic test_natural();
    bit ok; int cyc; logic [31:0] d;
    do_reset(1'b0);
    for (int k = 0; k < N; k++) begin fre[0][k] = 16'(k); fim[0][k] = 16'(-k); end
    build_expected(0, 1'b0);
    send_frame(0, 0, N, ok);
    checks++; if (!ok) begin errors++; $display("FAIL natural_send: got stall expected in_ready"); end
    wait_start(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL natural_start_delay: got %0d expected 1", cyc); end
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL natural_read ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    checks++; if (frame_start !== 1'b0 || frame_rdy !== 1'b1) begin errors++; $display("FAIL natural_flags: got start=%b rdy=%b expected 0 1", frame_start, frame_rdy); end
    core_release();
  endtask

  task automatic test_bitrev();
    bit ok; int cyc; logic [31:0] d;
    do_reset(1'b1);
    for (int k = 0; k < N; k++) begin fre[0][k] = 16'(k); fim[0][k] = 16'(k + 100); end
    build_expected(0, 1'b1);
    send_frame(0, 0, N, ok);
    wait_start(cyc);
    checks++; if (!ok || cyc < 0) begin errors++; $display("FAIL bitrev_frame: got ok=%b cyc=%0d expected frame", ok, cyc); end
    core_read(1, d);
    checks++; if (d[31:16] !== 16'd4) begin errors++; $display("FAIL bitrev_ad1: got %0d expected 4", d[31:16]); end
    core_read(3, d);
    checks++; if (d[31:16] !== 16'd6) begin errors++; $display("FAIL bitrev_ad3: got %0d expected 6", d[31:16]); end
    core_read(6, d);
    checks++; if (d[31:16] !== 16'd3) begin errors++; $display("FAIL bitrev_ad6: got %0d expected 3", d[31:16]); end
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL bitrev_read ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    core_release();
    bitrev_en = 1'b0;
  endtask

  task automatic test_core_write();
    bit ok; int cyc; logic [31:0] d, d2;
    do_reset(1'b0);
    gen_random(0);
    fre[0][2] = 16'hAAAA;
    build_expected(0, 1'b0);
    send_frame(0, 0, N, ok);
    wait_start(cyc);
    checks++; if (!ok || cyc < 0) begin errors++; $display("FAIL write_frame: got ok=%b cyc=%0d expected frame", ok, cyc); end
    core_read(2, d);
    checks++; if (d !== exp_mem[2]) begin errors++; $display("FAIL write_pre_read: got %h expected %h", d, exp_mem[2]); end
    core_ad = 3'd5; core_wre = 1'b1; core_din_re = 16'h1234; core_din_im = 16'h5678;
    exp_mem[5] = 32'h12345678;
    @(negedge clk);
    core_wre = 1'b0;
    d = {core_dout_re, core_dout_im};
    checks++; if (d !== exp_mem[2]) begin errors++; $display("FAIL write_dout_hold: got %h expected %h", d, exp_mem[2]); end
    core_read(5, d);
    d2 = {core_dout_re2, core_dout_im2};
    checks++; if (d !== 32'h12345678) begin errors++; $display("FAIL write_readback: got %h expected 12345678", d); end
    checks++; if (d2 !== exp_mem[2]) begin errors++; $display("FAIL lat2_early: got %h expected %h", d2, exp_mem[2]); end
    @(negedge clk);
    d2 = {core_dout_re2, core_dout_im2};
    checks++; if (d2 !== 32'h12345678) begin errors++; $display("FAIL lat2_readback: got %h expected 12345678", d2); end
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL write_read ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    core_release();
  endtask

  task automatic test_overrun();
    bit ok; int cyc, hi; logic [31:0] d;
    do_reset(1'b0);
    gen_random(0); gen_random(1); gen_random(2);
    send_frame(0, 0, N, ok);
    send_frame(1, 0, N, ok);
    checks++; if (!ok || overrun !== 1'b0) begin errors++; $display("FAIL ovr_two_frames: got ok=%b overrun=%b expected 1 0", ok, overrun); end
    hi = 0;
    repeat (8) begin
      if (in_ready !== 1'b0) hi++;
      @(negedge clk);
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL ovr_ready_low: got %0d ready cycles expected 0", hi); end
    in_valid = 1'b1; in_re = 16'hDEAD; in_im = 16'hBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    build_expected(0, 1'b0);
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL ovr_frame1 ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    core_release();
    wait_start(cyc);
    checks++; if (cyc !== 1 || in_ready !== 1'b1) begin errors++; $display("FAIL ovr_frame2_start: got cyc=%0d ready=%b expected 1 1", cyc, in_ready); end
    build_expected(1, 1'b0);
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL ovr_frame2 ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    send_frame(2, 0, N, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_frame3_send: got stall expected in_ready"); end
    core_release();
    wait_start(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL ovr_frame3_start: got %0d expected 1", cyc); end
    build_expected(2, 1'b0);
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL ovr_frame3 ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    core_release();
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; logic [31:0] d;
    do_reset(1'b0);
    gen_random(0); gen_random(1);
    send_frame(0, 0, N, ok);
    wait_start(cyc);
    send_frame(1, 0, N - 1, ok);
    checks++; if (!ok || in_ready !== 1'b1 || frame_rdy !== 1'b1) begin errors++; $display("FAIL b2b_setup: got ok=%b ready=%b rdy=%b expected 1 1 1", ok, in_ready, frame_rdy); end
    in_valid = 1'b1; in_re = fre[1][N-1]; in_im = fim[1][N-1]; core_done = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; core_done = 1'b0;
    checks++; if (in_ready !== 1'b0 || frame_start !== 1'b0 || frame_rdy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b start=%b rdy=%b expected 0 0 0", in_ready, frame_start, frame_rdy); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || frame_start !== 1'b1 || frame_rdy !== 1'b1) begin errors++; $display("FAIL b2b_handover: got ready=%b start=%b rdy=%b expected 1 1 1", in_ready, frame_start, frame_rdy); end
    build_expected(1, 1'b0);
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL b2b_frame ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    checks++; if (in_ready !== 1'b1 || frame_start !== 1'b0) begin errors++; $display("FAIL b2b_after: got ready=%b start=%b expected 1 0", in_ready, frame_start); end
    core_release();
  endtask

  task automatic test_reset_midframe();
    bit ok; int cyc, seen; logic [31:0] d;
    do_reset(1'b0);
    gen_random(2); gen_random(3);
    send_frame(2, 0, 5, ok);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || frame_rdy !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got ready=%b rdy=%b ovr=%b expected 1 0 0", in_ready, frame_rdy, overrun); end
    send_frame(3, 0, N - 1, ok);
    seen = 0;
    repeat (4) begin
      if (frame_start !== 1'b0 || frame_rdy !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++; if (!ok || seen !== 0) begin errors++; $display("FAIL mid_no_early_frame: got ok=%b early=%0d expected 1 0", ok, seen); end
    send_frame(3, N - 1, N, ok);
    wait_start(cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL mid_start: got %0d expected 1", cyc); end
    build_expected(3, 1'b0);
    for (int a = 0; a < N; a++) begin
      core_read(a, d);
      checks++; if (d !== exp_mem[a]) begin errors++; $display("FAIL mid_frame ad%0d: got %h expected %h", a, d, exp_mem[a]); end
    end
    core_release();
  endtask

  initial begin
    test_reset();
    test_natural();
    test_bitrev();
    test_core_write();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
